// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the Booth multiplier family.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG1,
    DIG_NEG2
  } digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t booth_decode(input logic [2:0] win);
    digit_t dig;
    case (win)
      3'b001, 3'b010: dig = DIG_POS1;
      3'b011:         dig = DIG_POS2;
      3'b100:         dig = DIG_NEG2;
      3'b101, 3'b110: dig = DIG_NEG1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Single radix-4 Booth digit partial-product selector (combinational).
// Negative digits are returned as one's complement; the +1 is o_neg and is
// meant to be folded into the consumer's adder as a carry-in.
module booth_r4_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+1:0] i_x,
  input  logic [2:0]       i_win,
  output logic [WIDTH+2:0] o_pp,
  output logic             o_neg
);

  digit_t           w_dig;
  logic [WIDTH+2:0] w_x1;
  logic [WIDTH+2:0] w_x2;

  assign w_dig = booth_decode(i_win);
  assign w_x1  = {i_x[WIDTH+1], i_x};
  assign w_x2  = {i_x, 1'b0};

  // Select 0 / X / 2X and their one's complements from the decoded digit.
  always_comb begin
    o_pp  = '0;
    o_neg = 1'b0;
    case (w_dig)
      DIG_POS1: o_pp = w_x1;
      DIG_POS2: o_pp = w_x2;
      DIG_NEG1: begin
        o_pp  = ~w_x1;
        o_neg = 1'b1;
      end
      DIG_NEG2: begin
        o_pp  = ~w_x2;
        o_neg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one digit per clock, valid/ready in and out.
// The accumulator is pre-scaled by 2^(WIDTH+2): each partial product is added
// at bit WIDTH+2 and the sum is shifted right arithmetically by 2, so after
// NDIG digits the accumulator holds the exact product.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NDIG  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(NDIG);
  localparam int ACC_W = 2 * WIDTH + 4;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_seq_mul: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [WIDTH+1:0]        r_x;
  logic [WIDTH+2:0]        r_mplr;
  logic signed [ACC_W-1:0] r_acc;
  logic [2*WIDTH-1:0]      r_prod;

  logic [WIDTH+2:0]        w_pp;
  logic                    w_neg;
  logic [WIDTH+1:0]        w_hi;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_unused_pp_msb;

  booth_r4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .i_x   (r_x),
    .i_win (r_mplr[2:0]),
    .o_pp  (w_pp),
    .o_neg (w_neg)
  );

  // The top pp bit only matters above the accumulator width; the add wraps modulo 2^ACC_W.
  assign w_unused_pp_msb = w_pp[WIDTH+2];
  assign w_hi      = r_acc[ACC_W-1:WIDTH+2] + w_pp[WIDTH+1:0] + {{(WIDTH+1){1'b0}}, w_neg};
  assign w_acc_sum = {w_hi, r_acc[WIDTH+1:0]};
  assign w_acc_nxt = w_acc_sum >>> 2;
  assign w_last    = (r_cnt == CNT_W'(NDIG - 1));
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign product   = r_prod;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_mplr <= '0;
      r_acc  <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_x    <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
      r_mplr <= signed_mode ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
      r_acc  <= '0;
    end else if (r_state == CALC) begin
      r_cnt  <= r_cnt + 1'b1;
      r_mplr <= {2'b00, r_mplr[WIDTH+2:2]};
      r_acc  <= w_acc_nxt;
      if (w_last) r_prod <= w_acc_nxt[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul at WIDTH=16 and WIDTH=8.
module tb_booth_r4_seq_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, sm16, ov16, or16, bsy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv8, ir8, sm8, ov8, or8, bsy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  booth_r4_seq_mul #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(bsy16)
  );

  booth_r4_seq_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bsy8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_prod(input bit w8);
    return w8 ? {16'h0, p8} : p16;
  endfunction
  function automatic logic cur_ov(input bit w8);
    return w8 ? ov8 : ov16;
  endfunction
  function automatic logic cur_ir(input bit w8);
    return w8 ? ir8 : ir16;
  endfunction
  function automatic logic cur_busy(input bit w8);
    return w8 ? bsy8 : bsy16;
  endfunction

  task automatic drive(input bit w8, input logic iv, input logic [31:0] av, input logic [31:0] bv,
                       input logic sm, input logic ordy);
    if (w8) begin
      iv8 = iv; a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; or8 = ordy;
    end else begin
      iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; sm16 = sm; or16 = ordy;
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input bit s);
    logic signed [31:0] sx, sy;
    logic [31:0] ux, uy;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    ux = {16'h0, x};
    uy = {16'h0, y};
    return s ? 32'(sx * sy) : 32'(ux * uy);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input bit s);
    logic signed [15:0] sx, sy;
    logic [15:0] ux, uy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    ux = {8'h0, x};
    uy = {8'h0, y};
    return s ? 16'(sx * sy) : 16'(ux * uy);
  endfunction

  // Full transaction: accept, scramble inputs, check latency/product, drain.
  task automatic run_vec(input string tag, input bit w8, input logic [31:0] av, input logic [31:0] bv,
                         input bit sm, input logic [31:0] exp);
    int lat;
    int ndig;
    ndig = w8 ? 5 : 9;
    lat = 0;
    while (!cur_ir(w8) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    drive(w8, 1'b1, av, bv, sm, 1'b0);
    @(posedge clk); #1;
    drive(w8, 1'b0, ~av, ~bv, ~sm, 1'b0);
    chk({tag, "/busy"}, cur_busy(w8), 1);
    lat = 0;
    while (!cur_ov(w8) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "/lat"}, lat, ndig);
    chk({tag, "/prod"}, cur_prod(w8), exp);
    drive(w8, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk({tag, "/ov_drop"}, cur_ov(w8), 0);
    chk({tag, "/ir_back"}, cur_ir(w8), 1);
    chk({tag, "/prod_hold"}, cur_prod(w8), exp);
    drive(w8, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] ra, rb;
    bit rs;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    #12;
    chk("rst/ir16", ir16, 1);
    chk("rst/ov16", ov16, 0);
    chk("rst/busy16", bsy16, 0);
    chk("rst/p16", p16, 0);
    chk("rst/ir8", ir8, 1);
    chk("rst/p8", p8, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("s_min_min", 1'b0, 32'h8000, 32'h8000, 1'b1, 32'h4000_0000);
    run_vec("u_ones", 1'b0, 32'hFFFF, 32'hFFFF, 1'b0, 32'hFFFE_0001);
    run_vec("s_ones", 1'b0, 32'hFFFF, 32'hFFFF, 1'b1, 32'h0000_0001);
    run_vec("u_zero", 1'b0, 32'h0000, 32'h1234, 1'b0, 32'h0000_0000);
    run_vec("s_zero", 1'b0, 32'h0000, 32'h0000, 1'b1, 32'h0000_0000);
    run_vec("s_max_min", 1'b0, 32'h7FFF, 32'h8000, 1'b1, 32'hC000_8000);
    run_vec("u_1234_5678", 1'b0, 32'h1234, 32'h5678, 1'b0, 32'h0626_0060);

    run_vec("w8_s_80_7f", 1'b1, 32'h80, 32'h7F, 1'b1, 32'h0000_C080);
    run_vec("w8_u_80_7f", 1'b1, 32'h80, 32'h7F, 1'b0, 32'h0000_3F80);
    run_vec("w8_u_ff_ff", 1'b1, 32'hFF, 32'hFF, 1'b0, 32'h0000_FE01);
    run_vec("w8_s_80_80", 1'b1, 32'h80, 32'h80, 1'b1, 32'h0000_4000);

    // Backpressure: hold out_ready low for 6 cycles while poking in_valid.
    drive(1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    lat = 0;
    while (!ov16 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp/lat", lat, 9);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 32'hAAAA, 32'h5555, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("bp/prod", p16, 32'h0000_000F);
      chk("bp/ov", ov16, 1);
      chk("bp/ir", ir16, 0);
    end
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bp/ov_drop", ov16, 0);
    chk("bp/ir_back", ir16, 1);
    chk("bp/prod_hold", p16, 32'h0000_000F);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp/no_accept", bsy16, 0);

    // Reset during digit 4 discards the in-flight result.
    drive(1'b0, 1'b1, 32'h1234, 32'h5678, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst/ov", ov16, 0);
    chk("midrst/prod", p16, 0);
    chk("midrst/ir", ir16, 1);
    chk("midrst/busy", bsy16, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_rst", 1'b0, 32'h0002, 32'hFFFD, 1'b1, 32'hFFFF_FFFA);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_vec("rnd16", 1'b0, ra, rb, rs, ref16(ra[15:0], rb[15:0], rs));
      run_vec("rnd8", 1'b1, ra, rb, rs, {16'h0, ref8(ra[7:0], rb[7:0], rs)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mul.md
Name: booth_r4_seq_mul

Overview:
Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the single-digit combinational Booth encoder. It accepts one operand pair per transaction over a valid/ready handshake and retires one Booth digit per clock. It returns the full-width product over a second valid/ready handshake. It serves datapath blocks that need a WIDTH x WIDTH product, signed or unsigned, with small area.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time check fails otherwise)
NDIG, WIDTH/2+1 (derived, localparam), number of radix-4 digits / CALC cycles

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier (Booth-recoded)
signed_mode  in  1  1 = both operands two's complement, 0 = both unsigned; sampled with a/b
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  a*b, exact for the sampled mode
busy  out  1  high in CALC or DONE

Behaviour:
- One clock, clk. rst_n is asynchronous, active-low.
- While rst_n is low or after reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal accumulator, operand regs and digit counter cleared.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on in_valid&in_ready.
  - a, b and signed_mode are captured on that edge; later changes are ignored.
  - Operands are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - The multiplier register gets an implicit 0 appended below its LSB.
  - Digit counter = 0.
- CALC: each edge retires digit i from multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1]=0).
  - 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - Negation is one's complement plus carry-in 1 into the accumulator add. No separate incrementer.
  - Accumulator is 2*WIDTH+4 bits, signed. Partial product i is weighted 4^i, either by shifting the accumulator right (arithmetic) by 2 per cycle or by an explicit shift; the choice is free, but the result must be bit-exact.
  - Counter increments. After digit NDIG-1: CALC -> DONE.
- Latency: operands accepted on edge k -> out_valid=1 after edge k+NDIG (9 cycles for WIDTH=16).
- DONE:
  - out_valid=1 and product = low 2*WIDTH bits of the accumulator.
  - product and out_valid hold stable until out_valid&out_ready.
  - On that edge -> IDLE, out_valid=0. product keeps its last value (not cleared).
- in_ready = (state==IDLE). No accept in CALC/DONE and no same-cycle bypass DONE->CALC. Throughput is one result per NDIG+2 cycles minimum.
- out_ready held high entering DONE: out_valid is high exactly one cycle.
- in_valid while not ready: ignored, no side effects.
- Arithmetic boundaries must be exact, including:
  - signed most-negative x most-negative
  - unsigned all-ones x all-ones
  - zero operands (accumulator adds 0; NDIG cycles still elapse; no early termination)
- Reset asserted mid-CALC or mid-DONE: immediate return to IDLE with reset values. The in-flight result is discarded and never presented.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, CALC, DONE}
  - digit-select enum {DIG_ZERO, DIG_POS1, DIG_POS2, DIG_NEG1, DIG_NEG2}
  - function booth_decode(3-bit window) -> digit enum
- Sub-module booth_r4_pp_sel, parametrised WIDTH: combinational.
  - Inputs: extended multiplicand and 3-bit window.
  - Outputs: (WIDTH+3)-bit partial product (0, X, 2X or their one's complement) and neg carry bit.
  - This is the generalised single-digit encoder, reused by future array multipliers.
- Top holds the FSM, counter, operand/accumulator registers and handshakes.

Test Plan:
- WIDTH=16, signed_mode=1, a=16'h8000, b=16'h8000 -> after 9 cycles out_valid=1, product=32'h4000_0000.
- WIDTH=16, signed_mode=0, a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE_0001. Same operands with signed_mode=1 -> 32'h0000_0001.
- WIDTH=8, signed_mode=1, a=8'h80, b=8'h7F -> product=16'hC080 after 5 cycles. signed_mode=0 -> 16'h3F80.
- Backpressure: complete a=3,b=5 with out_ready=0 for 6 cycles -> product=32'h0000_000F stable, out_valid=1, in_ready=0 throughout, in_valid pulses ignored. Raising out_ready -> IDLE next edge, in_ready=1.
- Reset mid-CALC: deassert rst_n at digit 4 of a=16'h1234,b=16'h5678 -> out_valid=0, product=0, in_ready=1 immediately. The next transaction a=2,b=-3 (signed) returns 32'hFFFF_FFFA with no leftover state.
- Randomised: 10k transactions, both modes, WIDTH in {4,8,16,32}, random valid/ready gaps -> every product matches the reference model. Latency is always NDIG. No lost or duplicated results.
